// File: rtl/tdm_pkg.sv
// Shared types and sizing for the 32-slot TDM transmitter.
package tdm_pkg;
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    localparam int SLOTS = 32;
    localparam int SEL_W = 5;

    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction
endpackage

// File: rtl/tdm_mux32_tx_slot_timer.sv
// Slot prescaler: counts 0..CLK_DIV-1 while enabled and flags the last cycle of a slot.
module slot_timer
    import tdm_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic slot_end
);
    localparam int CNT_W = cnt_width(CLK_DIV);
    localparam logic [CNT_W-1:0] TC = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign slot_end = enable && (cnt_q == TC);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/tdm_mux32_tx.sv
// 32-to-1 TDM transmitter: latches a word on handshake and sends it LSB first, one bit per slot.
// state | meaning
// IDLE  | in_ready high, waiting for in_valid
// SEND  | driving slot sel with y = latched bit[sel]
// DONE  | one-cycle done pulse, sel back to 0
module tdm_mux32_tx
    import tdm_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             y,
    output logic [SEL_W-1:0] sel,
    output logic             slot_valid,
    output logic             frame_start,
    output logic             done
);
    state_t           state_q, state_d;
    logic [SLOTS-1:0] shift_q, shift_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             y_q, y_d;
    logic             slot_valid_q, slot_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             done_q, done_d;
    logic             slot_end;
    logic             accept;

    slot_timer #(.CLK_DIV(CLK_DIV)) u_slot_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q != SEND),
        .enable   (state_q == SEND),
        .slot_end (slot_end)
    );

    assign in_ready = (state_q == IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        sel_d         = sel_q;
        y_d           = 1'b0;
        slot_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        done_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d       = SEND;
                    shift_d       = in_data;
                    sel_d         = '0;
                    y_d           = in_data[0];
                    slot_valid_d  = 1'b1;
                    frame_start_d = 1'b1;
                end
            end
            SEND: begin
                slot_valid_d = 1'b1;
                y_d          = shift_q[0];
                if (slot_end) begin
                    if (sel_q == SEL_W'(SLOTS - 1)) begin
                        state_d      = DONE;
                        sel_d        = '0;
                        slot_valid_d = 1'b0;
                        y_d          = 1'b0;
                        done_d       = 1'b1;
                    end else begin
                        // shift_q[0] always holds bit[sel], so the next bit is shift_q[1]
                        sel_d   = sel_q + SEL_W'(1);
                        shift_d = {1'b0, shift_q[SLOTS-1:1]};
                        y_d     = shift_q[1];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            sel_q         <= '0;
            y_q           <= 1'b0;
            slot_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            sel_q         <= sel_d;
            y_q           <= y_d;
            slot_valid_q  <= slot_valid_d;
            frame_start_q <= frame_start_d;
            done_q        <= done_d;
        end
    end

    assign y           = y_q;
    assign sel         = sel_q;
    assign slot_valid  = slot_valid_q;
    assign frame_start = frame_start_q;
    assign done        = done_q;
endmodule

// File: tb/tb_tdm_mux32_tx.sv
// Bench for tdm_mux32_tx: two instances (CLK_DIV 1 and 4) checked cycle by cycle against slot arithmetic.
module tb_tdm_mux32_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv1 = 1'b0, iv4 = 1'b0;
    logic [31:0] id1 = '0, id4 = '0;
    logic        rdy1, y1, sv1, fs1, dn1;
    logic        rdy4, y4, sv4, fs4, dn4;
    logic [4:0]  sel1, sel4;
    logic [31:0] cur_data;

    int vectors = 0;
    int miscompares = 0;

    // {in_ready, y, sel[4:0], slot_valid, frame_start, done}
    typedef logic [9:0] obs_t;

    always #5 clk = ~clk;

    tdm_mux32_tx #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .in_data(id1),
        .y(y1), .sel(sel1), .slot_valid(sv1), .frame_start(fs1), .done(dn1)
    );

    tdm_mux32_tx #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4), .in_data(id4),
        .y(y4), .sel(sel4), .slot_valid(sv4), .frame_start(fs4), .done(dn4)
    );

    function automatic obs_t get_obs(input int which);
        if (which == 1) return {rdy1, y1, sel1, sv1, fs1, dn1};
        return {rdy4, y4, sel4, sv4, fs4, dn4};
    endfunction

    function automatic obs_t mk(input logic r, input logic yy, input logic [4:0] s,
                                input logic v, input logic f, input logic d);
        return {r, yy, s, v, f, d};
    endfunction

    task automatic drive(input int which, input logic v, input logic [31:0] d);
        if (which == 1) begin
            iv1 = v;
            id1 = d;
        end else begin
            iv4 = v;
            id4 = d;
        end
        cur_data = d;
    endtask

    // Presents word and returns #1 after the accepting edge N.
    task automatic handshake(input int which, input logic [31:0] word, input bit keep);
        bit seen;
        seen = 1'b0;
        @(posedge clk);
        #1;
        drive(which, 1'b1, word);
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (get_obs(which)[9]) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL handshake dut%0d: in_ready stayed 0, required 1 within 200 cycles", which);
        end
        @(posedge clk);
        #1;
        drive(which, keep, $urandom);
    endtask

    // Checks cycles N+1..N+32*div+2 against the slot timing rules; recv is the demux view.
    task automatic run_frame(input int which, input int div, input logic [31:0] word,
                             input bit keep, input string tag, output logic [31:0] recv);
        int   last;
        obs_t got, exp;
        last = 32 * div + 2;
        recv = '0;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            got = get_obs(which);
            if (c <= 32 * div)
                exp = mk(1'b0, word[(c - 1) / div], 5'((c - 1) / div), 1'b1, c == 1, 1'b0);
            else if (c == 32 * div + 1)
                exp = mk(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
            else
                exp = mk(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL %s dut%0d cycle N+%0d: rdy/y/sel/sv/fs/done got %b required %b",
                         tag, which, c, got, exp);
            end
            if (got[2] === 1'b1) recv[got[7:3]] = got[8];
            if (c < last) begin
                @(posedge clk);
                #1;
                if (keep) drive(which, 1'b1, $urandom);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) begin
            @(negedge clk);
            vectors += 2;
            if (get_obs(1) !== mk(0, 0, 0, 0, 0, 0) || get_obs(4) !== mk(0, 0, 0, 0, 0, 0)) begin
                miscompares++;
                $display("FAIL reset_hold: got %b/%b required all zero", get_obs(1), get_obs(4));
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (get_obs(1) !== mk(1, 0, 0, 0, 0, 0) || get_obs(4) !== mk(1, 0, 0, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL reset_release: got %b/%b required %b", get_obs(1), get_obs(4), mk(1, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_idle();
        drive(1, 1'b0, $urandom);
        drive(4, 1'b0, $urandom);
        repeat (50) begin
            @(negedge clk);
            for (int w = 1; w <= 4; w += 3) begin
                vectors++;
                if (get_obs(w) !== mk(1, 0, 0, 0, 0, 0)) begin
                    miscompares++;
                    $display("FAIL idle dut%0d: got %b required %b", w, get_obs(w), mk(1, 0, 0, 0, 0, 0));
                end
            end
        end
    endtask

    task automatic test_single();
        logic [31:0] recv;
        handshake(1, 32'hA5A5_0F0F, 1'b0);
        run_frame(1, 1, 32'hA5A5_0F0F, 1'b0, "single", recv);
        vectors++;
        if (recv !== 32'hA5A5_0F0F) begin
            miscompares++;
            $display("FAIL single_word: got %h required %h", recv, 32'hA5A5_0F0F);
        end
    endtask

    task automatic test_div4();
        logic [31:0] recv;
        handshake(4, 32'h8000_0001, 1'b0);
        run_frame(4, 4, 32'h8000_0001, 1'b0, "div4", recv);
        vectors++;
        if (recv !== 32'h8000_0001) begin
            miscompares++;
            $display("FAIL div4_word: got %h required %h", recv, 32'h8000_0001);
        end
    endtask

    task automatic test_loopback();
        logic [31:0] w, recv;
        for (int i = 0; i < 18; i++) begin
            int which, div;
            which = (i < 16) ? 1 : 4;
            div   = (i < 16) ? 1 : 4;
            w = $urandom;
            handshake(which, w, 1'b0);
            run_frame(which, div, w, 1'b0, "loopback", recv);
            vectors++;
            if (recv !== w) begin
                miscompares++;
                $display("FAIL loopback dut%0d word %0d: got %h required %h", which, i, recv, w);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w, recv;
        w = $urandom;
        handshake(1, w, 1'b1);
        for (int f = 0; f < 4; f++) begin
            run_frame(1, 1, w, 1'b1, "b2b", recv);
            vectors++;
            if (recv !== w) begin
                miscompares++;
                $display("FAIL b2b_word frame %0d: got %h required %h", f, recv, w);
            end
            w = cur_data;
            @(posedge clk);
            #1;
            drive(1, f < 3, $urandom);
        end
        run_frame(1, 1, w, 1'b0, "b2b_last", recv);
        vectors++;
        if (recv !== w) begin
            miscompares++;
            $display("FAIL b2b_last_word: got %h required %h", recv, w);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w, recv;
        w = $urandom;
        handshake(1, w, 1'b0);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c < 18) begin
                @(posedge clk);
                #1;
            end
        end
        vectors++;
        if (sel1 !== 5'd17 || sv1 !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_slot17: sel=%0d sv=%b required sel=17 sv=1", sel1, sv1);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (get_obs(1) !== mk(0, 0, 0, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL mid_reset: got %b required %b", get_obs(1), mk(0, 0, 0, 0, 0, 0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            vectors++;
            if (get_obs(1) !== mk(1, 0, 0, 0, 0, 0)) begin
                miscompares++;
                $display("FAIL mid_after_reset: got %b required %b", get_obs(1), mk(1, 0, 0, 0, 0, 0));
            end
        end
        w = $urandom;
        handshake(1, w, 1'b0);
        run_frame(1, 1, w, 1'b0, "mid_next", recv);
        vectors++;
        if (recv !== w) begin
            miscompares++;
            $display("FAIL mid_next_word: got %h required %h", recv, w);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_div4();
        test_loopback();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
